mfp_ahb_uart_tx: RTL and testbench
==================================

Name: mfp_ahb_uart_tx

Overview:
- AHB-Lite slave UART transmitter peripheral; it drives a serial TX line in the opposite direction to the serial loader's UART_RX.
- Sits beside the GPIO slaves under the AHB decoder in mfp_ahb_withloader, and is selected by HSEL from that decoder.
- Software writes bytes into an 8-entry FIFO. A bit-serial engine emits 8N1 frames LSB-first at a programmable baud divisor.

Parameters:
- FIFO_DEPTH, 8, transmit FIFO entries; must be a power of 2, range 2..16.
- DIV_RESET, 433, reset value of BAUDDIV: 50 MHz / 115200 - 1.

Ports:
- HCLK  input  1  bus clock; all state changes on its rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from the AHB decoder.
- HADDR  input  32  address; only [3:2] is decoded.
- HTRANS  input  2  transfer type; bit 1 set means an active transfer.
- HWRITE  input  1  1 = write.
- HREADY  input  1  bus ready; qualifies the address phase.
- HWDATA  input  32  write data, data phase.
- HRDATA  output  32  read data, data phase.
- UART_TX  output  1  serial line; idle high.
- TX_IRQ  output  1  level interrupt: high while the FIFO is empty and the engine is idle.

Behaviour:
- Bus timing
  - Zero wait states; the slave never stalls.
  - Address phase is captured when HSEL & HTRANS[1] & HREADY. HADDR[3:2] and HWRITE are registered.
  - Write data is taken from HWDATA in the following cycle.
  - HRDATA is combinational from the registered address.
- Register map (word offsets)
  - 0x0 TXDATA
    - Write: push HWDATA[7:0] into the FIFO.
    - Read: returns 0.
  - 0x4 STATUS, read:
    - bit0 busy (engine not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - [8:4] count
  - 0x4 STATUS, write: a 1 in bit3 clears overflow.
  - 0x8 BAUDDIV: R/W [15:0]; upper bits read 0.
  - 0xC: reads 0; writes ignored.
- Reset: all of the following take effect in the cycle HRESET is sampled high, including mid-frame. A partial frame is abandoned with no completion.
  - HRDATA = 0, UART_TX = 1, TX_IRQ = 1.
  - FIFO emptied, count = 0, overflow = 0.
  - BAUDDIV = DIV_RESET.
  - FSM returns to IDLE.
- FIFO push/pop
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Count wraps never; read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Bit timing
  - Bit period = BAUDDIV+1 cycles.
  - The down-counter reloads from BAUDDIV at every bit start.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
  - BAUDDIV = 0 gives a 1-cycle bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TX = 1. If the FIFO is non-empty: pop into an 8-bit shift register and go to START next cycle.
  - START: UART_TX = 0 for one bit period, then go to DATA with bit index 0.
  - DATA: UART_TX = shift[0] for one bit period, then shift right. After the 8th bit go to STOP.
  - STOP: UART_TX = 1 for one bit period. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames); else go to IDLE.
  - UART_TX is driven from a register, so there are no glitches.
- Latency: from the TXDATA write data phase to the UART_TX falling edge is 2 cycles when idle (push cycle, pop cycle, then START).
- TX_IRQ = empty & (state == IDLE), registered.

Optional Feature:
- Macro: MFP_UART_TX_PARITY_EN.
- When defined:
  - BAUDDIV bit16 = parity enable and bit17 = odd parity; both R/W, reset 0.
  - When enabled, a PARITY state between DATA and STOP emits the XOR of the 8 data bits (inverted for odd) for one bit period.
  - The enable bits are sampled at START, so a change mid-frame does not affect the current frame.
- When undefined: no PARITY state, and BAUDDIV[31:16] read 0.

Decomposition:
- Shared header mfp_ahb_const.vh: register offsets (MFP_UART_TX_DATA/STATUS/BAUD word indices), STATUS bit positions, FSM state encodings.
- One sub-module: mfp_uart_tx_fifo, a synchronous FIFO.
  - Ports: push, pop, din, dout, count, full, empty.
  - dout valid while not empty; pop and push allowed in the same cycle.

Test Plan:
- Reset, then read STATUS and BAUDDIV -> STATUS = 0x4 (empty), BAUDDIV = 433, UART_TX = 1, TX_IRQ = 1.
- BAUDDIV = 3, write TXDATA 0xA5 -> UART_TX falls 2 cycles after the data phase; line reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; then TX_IRQ = 1.
- BAUDDIV = 1, write 9 bytes 0x00..0x08 back-to-back -> the 9th is accepted because the 1st was popped; no overflow; frames are contiguous with no idle cycle between STOP and START.
- BAUDDIV = 100, write 10 bytes rapidly -> count 8, full = 1, overflow = 1; write STATUS 0x8 -> overflow = 0 and count unchanged.
- Assert HRESET mid-DATA bit 3 -> the next cycle has UART_TX = 1, FSM IDLE, FIFO empty; a subsequent write transmits normally.
- With MFP_UART_TX_PARITY_EN: BAUDDIV = 0x30003, send 0x07 -> the bit after data is 0 (odd parity of three ones), followed by stop.

Source files
------------

// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Shared constants for the AHB UART transmitter: register word offsets, STATUS bit positions, FSM encoding.
// Optional parity support is selected with MFP_UART_TX_PARITY_EN.
package mfp_ahb_uart_tx_pkg;

  localparam logic [1:0] MFP_UART_TX_DATA   = 2'd0;
  localparam logic [1:0] MFP_UART_TX_STATUS = 2'd1;
  localparam logic [1:0] MFP_UART_TX_BAUD   = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

endpackage

// File: rtl/mfp_ahb_uart_tx_if.sv
// AHB-Lite slave-side bus bundle for the UART transmitter.
interface mfp_ahb_uart_tx_if;
  // Handshake: an address phase is valid when HSEL & HTRANS[1] & HREADY; the slave is always
  // ready (zero wait states), so HWDATA/HRDATA belong to the cycle right after a valid address phase.
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, input HRDATA);
  modport slave  (input HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, output HRDATA);
endinterface

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous byte FIFO; dout is valid while not empty, push and pop may coincide (also when full).
module mfp_uart_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_dout,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite UART transmitter: 8-entry FIFO feeding an 8N1 LSB-first serial engine with programmable divisor.
// Define MFP_UART_TX_PARITY_EN to add BAUDDIV[16] parity enable / [17] odd parity and a PARITY bit.
module mfp_ahb_uart_tx
  import mfp_ahb_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic               HCLK,
  input  logic               HRESET,
  mfp_ahb_uart_tx_if.slave   bus,
  output logic               UART_TX,
  output logic               TX_IRQ,
  output tx_state_e          o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        r_wr_pend;
  logic [1:0]  r_addr;
  logic [15:0] r_baud;
  logic        r_ovf;
  tx_state_e   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_irq;
`ifdef MFP_UART_TX_PARITY_EN
  logic        r_par_en_cfg;
  logic        r_par_odd_cfg;
  logic        r_par_en;
  logic        r_par_bit;
`endif

  logic        w_addr_phase;
  logic        w_push;
  logic        w_pop;
  logic        w_tick;
  logic [7:0]  w_dout;
  logic [AW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_addr_phase = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign w_push       = r_wr_pend & (r_addr == MFP_UART_TX_DATA);
  assign w_tick       = (r_cnt == 16'd0);
  // The engine pops only from IDLE or at the end of a STOP bit, which is what makes frames contiguous.
  assign w_pop        = ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_tick)) & ~w_empty;

  mfp_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.HWDATA[7:0]),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr_pend <= 1'b0;
      r_addr    <= 2'd0;
      r_baud    <= DIV_RESET;
      r_ovf     <= 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
      r_par_en_cfg  <= 1'b0;
      r_par_odd_cfg <= 1'b0;
`endif
    end else begin
      r_wr_pend <= w_addr_phase & bus.HWRITE;
      if (w_addr_phase) r_addr <= bus.HADDR[3:2];
      if (r_wr_pend && r_addr == MFP_UART_TX_BAUD) begin
        r_baud <= bus.HWDATA[15:0];
`ifdef MFP_UART_TX_PARITY_EN
        r_par_en_cfg  <= bus.HWDATA[16];
        r_par_odd_cfg <= bus.HWDATA[17];
`endif
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (r_wr_pend && r_addr == MFP_UART_TX_STATUS && bus.HWDATA[STAT_OVF]) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (r_addr)
      MFP_UART_TX_STATUS: begin
        w_rdata[STAT_BUSY]  = (r_state != ST_IDLE);
        w_rdata[STAT_FULL]  = w_full;
        w_rdata[STAT_EMPTY] = w_empty;
        w_rdata[STAT_OVF]   = r_ovf;
        w_rdata[STAT_CNT_LSB +: 5] = 5'(w_count);
      end
      MFP_UART_TX_BAUD: begin
        w_rdata[15:0] = r_baud;
`ifdef MFP_UART_TX_PARITY_EN
        w_rdata[17:16] = {r_par_odd_cfg, r_par_en_cfg};
`endif
      end
      default: ;
    endcase
  end

  assign bus.HRDATA = w_rdata;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_irq   <= 1'b1;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
`ifdef MFP_UART_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_irq <= w_empty & (r_state == ST_IDLE);
      if (!w_tick && r_state != ST_IDLE) r_cnt <= r_cnt - 16'd1;
      if (w_pop) begin
        // Parity configuration is frozen per frame at the moment the byte is loaded.
        r_state <= ST_START;
        r_tx    <= 1'b0;
        r_shift <= w_dout;
        r_cnt   <= r_baud;
`ifdef MFP_UART_TX_PARITY_EN
        r_par_en  <= r_par_en_cfg;
        r_par_bit <= (^w_dout) ^ r_par_odd_cfg;
`endif
      end else begin
        case (r_state)
          ST_IDLE: r_tx <= 1'b1;
          ST_START: if (w_tick) begin
            r_state <= ST_DATA;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_cnt   <= r_baud;
          end
          ST_DATA: if (w_tick) begin
            r_cnt <= r_baud;
            if (r_bit == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
`ifdef MFP_UART_TX_PARITY_EN
          ST_PARITY: if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
            r_cnt   <= r_baud;
          end
`endif
          ST_STOP: if (w_tick) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign UART_TX     = r_tx;
  assign TX_IRQ      = r_irq;
  assign o_dbg_state = r_state;

`ifdef MFP_UART_TX_PARITY_EN
  assign w_unused = &{1'b0, bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:18]};
`else
  assign w_unused = &{1'b0, bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:16]};
`endif

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Directed bench for mfp_ahb_uart_tx: bus register checks plus cycle-exact serial line checks.
module tb_mfp_ahb_uart_tx;
  import mfp_ahb_uart_tx_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      uart_tx;
  logic      tx_irq;
  tx_state_e dbg_state;
  int        total = 0;
  int        bad = 0;
  logic [0:0] exp_q[$];
  logic [31:0] rd;

  mfp_ahb_uart_tx_if bus();

  mfp_ahb_uart_tx dut (
    .HCLK        (clk),
    .HRESET      (rst),
    .bus         (bus),
    .UART_TX     (uart_tx),
    .TX_IRQ      (tx_irq),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a;
    @(negedge clk);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
    @(negedge clk);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic push_bit(input logic v, input int per);
    for (int c = 0; c < per; c++) exp_q.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] b, input int per);
    push_bit(1'b0, per);
    for (int k = 0; k < 8; k++) push_bit(b[k], per);
    push_bit(1'b1, per);
  endtask

  // scoreboard: compares the line at the current negedge, then once per cycle until the queue drains
  task automatic drain_stream(input string tag);
    logic [0:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(uart_tx), 32'(e));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, 32'(uart_tx), 32'(e));
    end
  endtask

  initial begin
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HREADY = 1'b1;
    bus.HADDR = 32'd0; bus.HWDATA = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(tx_irq), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_hrdata", bus.HRDATA, 32'd0);
    ahb_read(32'h4, rd); check("rst_status", rd, 32'h4);
    ahb_read(32'h8, rd); check("rst_baud", rd, 32'd433);
    ahb_write(32'hC, 32'hFFFF_FFFF);
    ahb_read(32'hC, rd); check("reg_c_read", rd, 32'd0);
    ahb_read(32'h0, rd); check("txdata_read", rd, 32'd0);

    // single frame 0xA5 at 4 cycles/bit, 2-cycle latency
    ahb_write(32'h8, 32'd3);
    ahb_write(32'h0, 32'hA5);
    @(negedge clk);
    check("pop_cycle_tx", 32'(uart_tx), 32'd1);
    push_frame(8'hA5, 4);
    @(negedge clk);
    drain_stream("frame_a5");
    repeat (2) @(negedge clk);
    check("a5_irq_after", 32'(tx_irq), 32'd1);
    check("a5_state_after", 32'(dbg_state), 32'(ST_IDLE));
    ahb_read(32'h4, rd); check("a5_status_after", rd, 32'h4);

    // nine back-to-back bytes at 2 cycles/bit
    ahb_write(32'h8, 32'd1);
    for (int b = 0; b < 9; b++) push_frame(8'(b), 2);
    fork
      for (int b = 0; b < 9; b++) ahb_write(32'h0, 32'(b));
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < 30) begin
          @(negedge clk);
          n++;
        end
        drain_stream("frames_9");
      end
    join
    repeat (3) @(negedge clk);
    ahb_read(32'h4, rd); check("nine_status", rd, 32'h4);

    // overflow: 10 bytes into a slow engine
    ahb_write(32'h8, 32'd100);
    for (int b = 0; b < 10; b++) ahb_write(32'h0, 32'h10 + 32'(b));
    check("ovf_irq_busy", 32'(tx_irq), 32'd0);
    ahb_read(32'h4, rd); check("ovf_status", rd, 32'h8B);
    ahb_write(32'h4, 32'h8);
    ahb_read(32'h4, rd); check("ovf_cleared", rd, 32'h83);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ahb_read(32'h4, rd); check("rst2_status", rd, 32'h4);
    ahb_read(32'h8, rd); check("rst2_baud", rd, 32'd433);

    // reset in the middle of data bit 3
    ahb_write(32'h8, 32'd3);
    ahb_write(32'h0, 32'h00);
    repeat (19) @(negedge clk);
    check("bit3_tx", 32'(uart_tx), 32'd0);
    check("bit3_state", 32'(dbg_state), 32'(ST_DATA));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(uart_tx), 32'd1);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_irq", 32'(tx_irq), 32'd1);
    rst = 1'b0;
    ahb_read(32'h4, rd); check("midrst_status", rd, 32'h4);

    // divisor 0: one-cycle bits after reset recovery
    ahb_write(32'h8, 32'd0);
    ahb_write(32'h0, 32'h5A);
    @(negedge clk);
    check("div0_pop_tx", 32'(uart_tx), 32'd1);
    push_frame(8'h5A, 1);
    @(negedge clk);
    drain_stream("frame_5a_div0");
    repeat (3) @(negedge clk);

    // upper BAUDDIV bits and (optionally) odd parity on 0x07
    ahb_write(32'h8, 32'h0003_0003);
    ahb_read(32'h8, rd);
`ifdef MFP_UART_TX_PARITY_EN
    check("baud_upper", rd, 32'h0003_0003);
`else
    check("baud_upper", rd, 32'h0000_0003);
`endif
    ahb_write(32'h0, 32'h07);
    @(negedge clk);
    check("b07_pop_tx", 32'(uart_tx), 32'd1);
`ifdef MFP_UART_TX_PARITY_EN
    push_bit(1'b0, 4);
    for (int k = 0; k < 8; k++) push_bit((k < 3) ? 1'b1 : 1'b0, 4);
    push_bit(1'b0, 4);
    push_bit(1'b1, 4);
`else
    push_frame(8'h07, 4);
`endif
    @(negedge clk);
    drain_stream("frame_07");
    repeat (2) @(negedge clk);
    check("final_irq", 32'(tx_irq), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
